// File: rtl/hp_au_pkg.sv
// Shared opcode map, FSM encoding and issue-classification helper for the
// sequential HP-AU.
package hp_au_pkg;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_PASS_A = 4'd2;
  localparam logic [3:0] OP_NOT_A  = 4'd3;
  localparam logic [3:0] OP_AND    = 4'd4;
  localparam logic [3:0] OP_OR     = 4'd5;
  localparam logic [3:0] OP_XOR    = 4'd6;
  localparam logic [3:0] OP_SHL1   = 4'd7;
  localparam logic [3:0] OP_MUL    = 4'd8;
  localparam logic [3:0] OP_DIV    = 4'd9;

  localparam logic MODE_MUL = 1'b0;
  localparam logic MODE_DIV = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // b is passed zero-extended to 32 bits so the helper serves any legal WIDTH.
  function automatic logic is_iterative(input logic [3:0] sel, input logic [31:0] b);
    return (sel == OP_MUL) || ((sel == OP_DIV) && (b != 32'd0));
  endfunction

endpackage

// File: rtl/hp_au_iter_core.sv
// Shared shift register / accumulator for shift-add multiply and restoring
// divide; one iteration per step, hi_nxt/lo_nxt show the post-step values.
module hp_au_iter_core
  import hp_au_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             step,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_nxt,
  output logic [WIDTH-1:0] lo_nxt
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic             mode_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;

  // MUL: hi accumulates, lo shifts the multiplier out and product bits in.
  // DIV: hi is the partial remainder, lo shifts dividend out and quotient in;
  // bit WIDTH of div_diff is the borrow that decides restore vs. keep.
  always_comb begin
    mul_addend = lo_q[0] ? opnd_q : '0;
    mul_sum    = {1'b0, hi_q} + {1'b0, mul_addend};
    div_shift  = {hi_q, lo_q[WIDTH-1]};
    div_diff   = div_shift - {1'b0, opnd_q};
    hi_nxt     = mul_sum[WIDTH:1];
    lo_nxt     = {mul_sum[0], lo_q[WIDTH-1:1]};
    if (mode_q == MODE_DIV) begin
      if (!div_diff[WIDTH]) begin
        hi_nxt = div_diff[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_nxt = div_shift[WIDTH-1:0];
        lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done = (cnt_q == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      mode_q <= MODE_MUL;
      cnt_q  <= '0;
    end else if (start) begin
      hi_q   <= '0;
      lo_q   <= a;
      opnd_q <= b;
      mode_q <= mode;
      cnt_q  <= CNT_W'(WIDTH);
    end else if (step) begin
      hi_q   <= hi_nxt;
      lo_q   <= lo_nxt;
      cnt_q  <= cnt_q - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hp_au_seq.sv
// Multi-cycle HP-AU: valid/ready handshake, single-cycle ALU, iterative
// MUL/DIV through hp_au_iter_core, registered results and status flags.
module hp_au_seq
  import hp_au_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_zero,
  output logic             flag_carry,
  output logic             flag_ovf,
  output logic             flag_err
);

  localparam int MSB = WIDTH - 1;

  state_t           state;
  logic             op_is_mul;
  logic             accept;
  logic             iter;
  logic             core_done;
  logic [WIDTH-1:0] core_hi;
  logic [WIDTH-1:0] core_lo;

  logic [WIDTH:0]   alu_sum;
  logic [WIDTH:0]   alu_dif;
  logic [WIDTH-1:0] alu_res;
  logic [WIDTH-1:0] alu_hi;
  logic             alu_z;
  logic             alu_c;
  logic             alu_v;
  logic             alu_e;

  assign accept = in_valid && in_ready;
  assign iter   = is_iterative(sel, 32'(b));

  hp_au_iter_core #(.WIDTH(WIDTH)) u_core (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && iter),
    .mode   ((sel == OP_DIV) ? MODE_DIV : MODE_MUL),
    .step   (state == ST_BUSY),
    .a      (a),
    .b      (b),
    .done   (core_done),
    .hi_nxt (core_hi),
    .lo_nxt (core_lo)
  );

  // Single-cycle path; also resolves divide-by-zero and illegal opcodes,
  // which never enter BUSY.
  always_comb begin
    alu_sum = {1'b0, a} + {1'b0, b};
    alu_dif = {1'b0, a} - {1'b0, b};
    alu_res = '0;
    alu_hi  = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_e   = 1'b0;
    case (sel)
      OP_ADD: begin
        alu_res = alu_sum[WIDTH-1:0];
        alu_c   = alu_sum[WIDTH];
        alu_v   = (a[MSB] == b[MSB]) && (alu_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        alu_res = alu_dif[WIDTH-1:0];
        alu_c   = alu_dif[WIDTH];
        alu_v   = (a[MSB] != b[MSB]) && (alu_dif[MSB] != a[MSB]);
      end
      OP_PASS_A: alu_res = a;
      OP_NOT_A:  alu_res = ~a;
      OP_AND:    alu_res = a & b;
      OP_OR:     alu_res = a | b;
      OP_XOR:    alu_res = a ^ b;
      OP_SHL1: begin
        alu_res = {a[MSB-1:0], 1'b0};
        alu_c   = a[MSB];
      end
      OP_DIV: begin
        alu_res = '1;
        alu_hi  = a;
        alu_e   = 1'b1;
      end
      default: alu_e = 1'b1;
    endcase
    alu_z = (alu_res == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      op_is_mul  <= 1'b0;
      result     <= '0;
      result_hi  <= '0;
      flag_zero  <= 1'b0;
      flag_carry <= 1'b0;
      flag_ovf   <= 1'b0;
      flag_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (iter) begin
              state     <= ST_BUSY;
              op_is_mul <= (sel == OP_MUL);
            end else begin
              state      <= ST_DONE;
              out_valid  <= 1'b1;
              result     <= alu_res;
              result_hi  <= alu_hi;
              flag_zero  <= alu_z;
              flag_carry <= alu_c;
              flag_ovf   <= alu_v;
              flag_err   <= alu_e;
            end
          end
        end
        ST_BUSY: begin
          if (core_done) begin
            state      <= ST_DONE;
            out_valid  <= 1'b1;
            result     <= core_lo;
            result_hi  <= core_hi;
            flag_zero  <= (core_lo == '0);
            flag_carry <= op_is_mul && (core_hi != '0);
            flag_ovf   <= 1'b0;
            flag_err   <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hp_au_seq.sv
// Self-checking bench for hp_au_seq: directed scenarios plus randomized
// operations checked against an arithmetic reference model.
module tb_hp_au_seq;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [3:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         flag_zero;
  logic         flag_carry;
  logic         flag_ovf;
  logic         flag_err;

  int checks = 0;
  int errors = 0;

  hp_au_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .sel        (sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .result_hi  (result_hi),
    .flag_zero  (flag_zero),
    .flag_carry (flag_carry),
    .flag_ovf   (flag_ovf),
    .flag_err   (flag_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference behaviour from plain integer arithmetic.
  function automatic void model(input int ma, input int mb, input int ms,
                                output int r, output int rh,
                                output bit z, output bit c, output bit v, output bit e,
                                output int lat);
    int mask;
    int smax;
    int smin;
    int sa;
    int sb;
    int s;
    mask = (1 << W) - 1;
    smax = (1 << (W - 1)) - 1;
    smin = -(1 << (W - 1));
    sa = (ma > smax) ? ma - (1 << W) : ma;
    sb = (mb > smax) ? mb - (1 << W) : mb;
    r = 0; rh = 0; c = 0; v = 0; e = 0; lat = 1;
    case (ms)
      0: begin s = ma + mb; r = s & mask; c = (s > mask); v = (sa + sb > smax) || (sa + sb < smin); end
      1: begin r = (ma - mb) & mask; c = (ma < mb); v = (sa - sb > smax) || (sa - sb < smin); end
      2: r = ma;
      3: r = (~ma) & mask;
      4: r = ma & mb;
      5: r = ma | mb;
      6: r = ma ^ mb;
      7: begin r = (ma * 2) & mask; c = (ma > smax); end
      8: begin s = ma * mb; r = s & mask; rh = s >> W; c = (rh != 0); lat = W + 1; end
      9: begin
        if (mb == 0) begin r = mask; rh = ma; e = 1; end
        else begin r = ma / mb; rh = ma % mb; lat = W + 1; end
      end
      default: e = 1;
    endcase
    z = (r == 0);
  endfunction

  // Issue one operation, measure accept-to-out_valid latency, collect outputs.
  task automatic run_op(input logic [W-1:0] opa, input logic [W-1:0] opb, input logic [3:0] ops,
                        input int stall, output int lat,
                        output logic [W-1:0] r, output logic [W-1:0] rh, output logic [3:0] fl);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid  = 1'b1;
    a         = opa;
    b         = opb;
    sel       = ops;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    a        = W'($urandom);
    b        = W'($urandom);
    sel      = 4'($urandom);
    lat = 1;
    while (!out_valid && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    r  = result;
    rh = result_hi;
    fl = {flag_zero, flag_carry, flag_ovf, flag_err};
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = '0;
    b         = '0;
    sel       = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    checks++;
    if ({result, result_hi} !== '0) begin errors++; $display("FAIL reset_result got %h/%h exp 0/0", result, result_hi); end
    checks++;
    if ({flag_zero, flag_carry, flag_ovf, flag_err} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp 0000", {flag_zero, flag_carry, flag_ovf, flag_err});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int lat;
    logic [W-1:0] r, rh;
    logic [3:0] fl;
    // fl = {zero, carry, ovf, err}
    run_op(4'b1100, 4'b1010, 4'd4, 0, lat, r, rh, fl);
    checks++; if (lat !== 1) begin errors++; $display("FAIL and_latency got %0d exp 1", lat); end
    checks++; if (r !== 4'b1000) begin errors++; $display("FAIL and_result got %b exp 1000", r); end
    checks++; if (fl !== 4'b0000) begin errors++; $display("FAIL and_flags got %b exp 0000", fl); end

    run_op(4'd3, 4'd2, 4'd8, 0, lat, r, rh, fl);
    checks++; if (lat !== 5) begin errors++; $display("FAIL mul_latency got %0d exp 5", lat); end
    checks++; if ({rh, r} !== 8'd6) begin errors++; $display("FAIL mul_3x2 got %0d:%0d exp 0:6", rh, r); end
    checks++; if (fl[2] !== 1'b0) begin errors++; $display("FAIL mul_3x2_carry got %b exp 0", fl[2]); end

    run_op(4'd4, 4'd4, 4'd8, 0, lat, r, rh, fl);
    checks++; if ({rh, r} !== 8'h10) begin errors++; $display("FAIL mul_4x4 got %0d:%0d exp 1:0", rh, r); end
    checks++; if (fl !== 4'b1100) begin errors++; $display("FAIL mul_4x4_flags got %b exp 1100", fl); end

    run_op(4'd13, 4'd3, 4'd9, 0, lat, r, rh, fl);
    checks++; if (lat !== 5) begin errors++; $display("FAIL div_latency got %0d exp 5", lat); end
    checks++; if ({rh, r} !== {4'd1, 4'd4}) begin errors++; $display("FAIL div_13_3 got q=%0d r=%0d exp q=4 r=1", r, rh); end

    run_op(4'd7, 4'd0, 4'd9, 0, lat, r, rh, fl);
    checks++; if (lat !== 1) begin errors++; $display("FAIL div0_latency got %0d exp 1", lat); end
    checks++; if ({rh, r} !== {4'd7, 4'b1111}) begin errors++; $display("FAIL div0_result got %b/%b exp 0111/1111", rh, r); end
    checks++; if (fl !== 4'b0001) begin errors++; $display("FAIL div0_flags got %b exp 0001", fl); end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] r0, rh0;
    logic [3:0] f0;
    int guard;
    in_valid  = 1'b1;
    a         = 4'd9;
    b         = 4'd6;
    sel       = 4'd6;
    out_ready = 1'b0;
    @(posedge clk); #1;
    a   = 4'd5;
    b   = 4'd5;
    sel = 4'd0;
    guard = 0;
    while (!out_valid && guard < 20) begin @(posedge clk); #1; guard++; end
    r0 = result; rh0 = result_hi; f0 = {flag_zero, flag_carry, flag_ovf, flag_err};
    checks++; if (r0 !== 4'b1111) begin errors++; $display("FAIL bp_first_result got %b exp 1111", r0); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== r0 || result_hi !== rh0 ||
          {flag_zero, flag_carry, flag_ovf, flag_err} !== f0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got ov=%b ir=%b res=%b exp ov=1 ir=0 res=%b", i, out_valid, in_ready, result, r0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || result !== 4'b1010 || flag_ovf !== 1'b1 || flag_carry !== 1'b0) begin
      errors++; $display("FAIL bp_next_add got ov=%b res=%b ovf=%b c=%b exp ov=1 res=1010 ovf=1 c=0", out_valid, result, flag_ovf, flag_carry);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int seen;
    seen      = 0;
    in_valid  = 1'b1;
    a         = 4'd3;
    b         = 4'd2;
    sel       = 4'd0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (in_ready !== !out_valid) begin
        errors++; $display("FAIL b2b_ready cycle %0d got ir=%b ov=%b exp ir=!ov", i, in_ready, out_valid);
      end
      if (out_valid) begin
        seen++;
        checks++;
        if (result !== 4'd5) begin errors++; $display("FAIL b2b_result got %0d exp 5", result); end
      end
    end
    in_valid = 1'b0;
    checks++;
    if (seen !== 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", seen); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_op();
    int lat;
    int seen;
    logic [W-1:0] r, rh;
    logic [3:0] fl;
    in_valid = 1'b1;
    a        = 4'd7;
    b        = 4'd9;
    sel      = 4'd8;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_handshake got ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready);
    end
    checks++;
    if ({result, result_hi, flag_zero, flag_carry, flag_ovf, flag_err} !== '0) begin
      errors++; $display("FAIL midrst_outputs got %b/%b/%b exp all 0", result, result_hi, {flag_zero, flag_carry, flag_ovf, flag_err});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    repeat (W + 3) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen !== 0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL midrst_abort got out_valid_cycles=%0d ir=%b exp 0 and 1", seen, in_ready);
    end
    run_op(4'd3, 4'd5, 4'd12, 0, lat, r, rh, fl);
    checks++;
    if (lat !== 1 || fl !== 4'b1001 || {rh, r} !== '0) begin
      errors++; $display("FAIL illegal_op got lat=%0d fl=%b res=%b/%b exp lat=1 fl=1001 res=0/0", lat, fl, rh, r);
    end
  endtask

  task automatic test_random();
    int lat, elat, er, erh;
    bit ez, ec, ev, ee;
    logic [W-1:0] ra, rb, r, rh;
    logic [3:0] rs, fl;
    for (int n = 0; n < 60; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      rs = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 9)) : 4'($urandom);
      model(int'(ra), int'(rb), int'(rs), er, erh, ez, ec, ev, ee, elat);
      run_op(ra, rb, rs, $urandom_range(0, 2), lat, r, rh, fl);
      checks++;
      if (lat !== elat) begin errors++; $display("FAIL rnd_latency sel=%0d a=%0d b=%0d got %0d exp %0d", rs, ra, rb, lat, elat); end
      checks++;
      if (int'(r) !== er || int'(rh) !== erh) begin
        errors++; $display("FAIL rnd_result sel=%0d a=%0d b=%0d got %0d:%0d exp %0d:%0d", rs, ra, rb, rh, r, erh, er);
      end
      checks++;
      if (fl !== {ez, ec, ev, ee}) begin
        errors++; $display("FAIL rnd_flags sel=%0d a=%0d b=%0d got %b exp %b", rs, ra, rb, fl, {ez, ec, ev, ee});
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hp_au_seq.md
Name: hp_au_seq

Overview:
Parametrised, multi-cycle successor to the combinational HP-AU top.
- Keeps the 4-bit opcode map: AND in slot 4, MUL in slot 8.
- Adds a registered valid/ready handshake, iterative MUL (full 2*WIDTH product) and DIV/MOD, status flags and an error indication.
- Sits between an instruction/issue stage and a writeback stage; one operation is in flight at a time.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- in_valid  in  1  operation request valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A, unsigned.
- b  in  WIDTH  operand B, unsigned.
- sel  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  primary result: low product, quotient, or ALU result.
- result_hi  out  WIDTH  high product half (MUL) or remainder (DIV); 0 for other ops.
- flag_zero  out  1  result == 0.
- flag_carry  out  1  carry (ADD), borrow (SUB), result_hi != 0 (MUL); 0 otherwise.
- flag_ovf  out  1  two's-complement overflow (ADD/SUB only).
- flag_err  out  1  illegal opcode or divide by zero.

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - in_ready = 1.
  - out_valid, result, result_hi and all flags = 0.
  - Internal counter and accumulators are cleared.
- Opcodes:
  - 0 ADD, 1 SUB, 2 PASS_A, 3 NOT_A, 4 AND, 5 OR, 6 XOR, 7 SHL1 (carry = a[MSB]), 8 MUL, 9 DIV.
  - 10..15 are illegal.
- Handshake:
  - An operation is accepted on a cycle with in_valid && in_ready.
  - a, b and sel are captured at accept; later input changes are ignored.
  - The result is transferred on out_valid && out_ready.
  - in_ready = 1 only in IDLE.
- FSM states: IDLE, BUSY, DONE.
  - IDLE, accept of sel 0..7, illegal opcode, or DIV with b == 0: go to DONE next edge (latency 1 cycle).
  - IDLE, accept of MUL, or DIV with b != 0: go to BUSY with counter = WIDTH.
  - BUSY: one iteration per cycle, counter decrements; at counter == 1 go to DONE. Accept-to-out_valid latency is WIDTH+1 cycles.
  - DONE: out_valid = 1; outputs held stable until out_ready. If out_ready, go to IDLE on that edge.
- Output update rules:
  - Outputs change only on entry to DONE.
  - out_valid deasserts on the cycle after the handshake.
  - result and flags hold their last values in IDLE.
- MUL:
  - Shift-add over WIDTH cycles; {result_hi, result} = a*b exactly.
  - result alone is the truncated product, matching the combinational block.
- DIV:
  - Restoring division over WIDTH cycles; result = a/b, result_hi = a%b.
- Divide by zero (b == 0):
  - No BUSY phase.
  - result = all ones, result_hi = a, flag_err = 1, flag_zero = 0.
- Illegal opcode: result = 0, result_hi = 0, flag_err = 1, flag_zero = 1.
- ADD/SUB:
  - Computed in WIDTH+1 bits.
  - flag_ovf = operand sign bits equal (ADD) / differ (SUB) and result sign differs from a.
- No accept while BUSY or DONE; in_valid held high simply waits.
- Reset asserted mid-BUSY or in DONE: the operation is aborted with no output produced, and the block is back in IDLE with in_ready = 1 after release.

Decomposition:
- Package hp_au_pkg holds:
  - opcode localparams OP_ADD..OP_DIV (values 0..9);
  - state encoding ST_IDLE/ST_BUSY/ST_DONE (2 bits);
  - a function is_iterative(sel, b).
- Sub-module hp_au_iter_core holds the shared shift register/accumulator datapath for shift-add multiply and restoring divide, with start, mode, step and done.
- The top hp_au_seq holds the FSM, handshake, single-cycle ALU and flag logic.

Test Plan:
- WIDTH=4, a=1100, b=1010, sel=4, out_ready=1 -> out_valid 1 cycle after accept; result=1000, flags zero/carry/ovf/err = 0.
- a=3, b=2, sel=8 -> out_valid exactly 5 cycles after accept; result=6, result_hi=0, flag_carry=0.
- a=4, b=4, sel=8 -> result=0, result_hi=1, flag_zero=1, flag_carry=1 (truncation visible).
- a=13, b=3, sel=9 -> result=4, result_hi=1; then a=7, b=0, sel=9 -> 1-cycle latency, result=1111, result_hi=7, flag_err=1.
- Backpressure: out_ready low for 3 cycles in DONE -> outputs stable and in_ready=0 throughout; a new in_valid with a=5, b=5, sel=0 is accepted only after the handshake, giving result=1010, flag_ovf=1.
- Reset mid-operation: rst_n low for 1 cycle during MUL BUSY -> all outputs 0 immediately, in_ready=1; no out_valid is produced; the next op (sel=12) gives flag_err=1.
